// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: byte FIFO plus launch sequencer feeding uart_tx.
// Bytes written by the host are queued and launched one at a time, paced by
// uart_tx's busy/tx_done handshake; a launch that never sees busy is dropped.
module uart_tx_fifo_ctrl #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned BUSY_TIMEOUT = 15,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          tx_clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          timeout_err,
  output logic          start,
  output logic [7:0]    tx_parallel_data,
  input  logic          busy,
  input  logic          tx_done
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TW-1:0]   tcnt;
  logic [TW-1:0]   tcnt_next;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            drop;
  logic            pop;
  logic            to_fire;

  // Host write acceptance: a full FIFO drops the byte even if a pop coincides.
  always_comb begin
    push = wr_en & ~full;
    drop = wr_en & full;
  end

  // Next-state, pop and timeout decisions for the launch sequencer.
  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    pop        = 1'b0;
    to_fire    = 1'b0;
    case (state)
      S_IDLE: begin
        tcnt_next = '0;
        if (!empty && !busy) begin
          pop        = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (busy) begin
          tcnt_next  = '0;
          state_next = tx_done ? S_IDLE : S_WAIT_DONE;
        end else if (tcnt == TO_LAST) begin
          tcnt_next  = '0;
          to_fire    = 1'b1;
          state_next = S_IDLE;
        end else begin
          tcnt_next = tcnt + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        tcnt_next  = '0;
      end
    endcase
  end

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // State register, timeout counter and registered outputs.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      tcnt             <= '0;
      start            <= 1'b0;
      overflow         <= 1'b0;
      timeout_err      <= 1'b0;
      tx_parallel_data <= 8'h00;
    end else begin
      state       <= state_next;
      tcnt        <= tcnt_next;
      start       <= (state_next == S_LAUNCH);
      overflow    <= drop;
      timeout_err <= to_fire;
      if (pop) begin
        tx_parallel_data <= mem[rd_ptr];
      end
    end
  end

  // FIFO pointers and occupancy flags.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge tx_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule
